// File: rtl/param_dump_tx.sv
// UART 8N1 read-back of the parameter RAM: HEADER, RAM[0..NUM_BYTES-1], then an 8-bit checksum.
// The checksum is the sum of the data bytes only; the header is not included.
//
// state | meaning
// IDLE  | line high, waiting for dump_req
// START | start bit (low) of the current byte
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); next byte loaded on its last clk
module param_dump_tx #(
    parameter int          CLK_HZ    = 50_000_000,
    parameter int          BAUD      = 9600,
    parameter int          NUM_BYTES = 10,
    parameter logic [7:0]  HEADER    = 8'hA5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       dump_req,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       tx_out,
    output logic       busy,
    output logic       done
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int TW           = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [8:0]    N_DATA    = 9'(NUM_BYTES);
    localparam logic [8:0]    LAST_IDX  = 9'(NUM_BYTES + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [8:0]    byte_idx;
    logic [7:0]    shreg;
    logic [7:0]    chk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            timer    <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
            chk      <= '0;
            rd_addr  <= '0;
            tx_out   <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx_out <= 1'b1;
                    if (dump_req) begin
                        state    <= START;
                        tx_out   <= 1'b0;
                        busy     <= 1'b1;
                        timer    <= BIT_LAST;
                        shreg    <= HEADER;
                        byte_idx <= '0;
                        chk      <= '0;
                        rd_addr  <= '0;
                    end
                end
                START: begin
                    if (timer == '0) begin
                        state   <= DATA;
                        timer   <= BIT_LAST;
                        bit_idx <= '0;
                        tx_out  <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                DATA: begin
                    if (timer == '0) begin
                        timer <= BIT_LAST;
                        if (bit_idx == 3'd7) begin
                            state  <= STOP;
                            tx_out <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx_out  <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                STOP: begin
                    if (timer == '0) begin
                        if (byte_idx == LAST_IDX) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            // rd_data was addressed a full byte time ago, so it is settled here
                            state    <= START;
                            tx_out   <= 1'b0;
                            timer    <= BIT_LAST;
                            byte_idx <= byte_idx + 1'b1;
                            if (byte_idx < N_DATA) begin
                                shreg <= rd_data;
                                chk   <= chk + rd_data;
                            end else begin
                                shreg <= chk;
                            end
                            if ((byte_idx + 9'd1) < N_DATA)
                                rd_addr <= rd_addr + 1'b1;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_param_dump_tx.sv
// Directed bench for param_dump_tx: 10 clks/bit, 10 data bytes, frames sampled every clk and decoded.
module tb_param_dump_tx;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       dump_req = 1'b0;
    logic [7:0] rd_addr;
    logic [7:0] rd_data = 8'h00;
    logic       tx_out;
    logic       busy;
    logic       done;

    param_dump_tx #(
        .CLK_HZ(1_000_000), .BAUD(100_000), .NUM_BYTES(10), .HEADER(8'hA5)
    ) dut (
        .clk(clk), .reset_n(reset_n), .dump_req(dump_req), .rd_addr(rd_addr),
        .rd_data(rd_data), .tx_out(tx_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:255];
    always @(posedge clk) rd_data <= ram[rd_addr];

    int errors = 0;
    int checks = 0;

    logic       line [0:1199];
    logic [7:0] cap [0:11];
    logic [7:0] exp_b [0:11];
    int         glitch, busy_cnt, done_cnt;
    logic       post_busy, post_done;
    logic [7:0] addr0;

    // Fill RAM with a*i+b and build the expected frame from it.
    task automatic load_ram(input int a, input int b);
        logic [7:0] sum;
        sum = 8'h00;
        for (int i = 0; i < 256; i++) ram[i] = 8'(a * i + b);
        exp_b[0] = 8'hA5;
        for (int i = 0; i < 10; i++) begin
            exp_b[i+1] = ram[i];
            sum = sum + ram[i];
        end
        exp_b[11] = sum;
    endtask

    // Samples one 1200-clk frame window at negedges, then the clk after it, and decodes it.
    task automatic capture_frame();
        int base;
        glitch = 0; busy_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 1200; c++) begin
            @(negedge clk);
            line[c] = tx_out;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) done_cnt++;
            if (c == 0) addr0 = rd_addr;
        end
        @(negedge clk);
        post_busy = busy;
        post_done = done;
        for (int i = 0; i < 12; i++) begin
            cap[i] = 8'h00;
            for (int b = 0; b < 10; b++) begin
                base = (i * 10 + b) * 10;
                for (int s = 1; s < 10; s++)
                    if (line[base+s] !== line[base]) glitch++;
                if (b == 0 && line[base] !== 1'b0) glitch++;
                if (b == 9 && line[base] !== 1'b1) glitch++;
                if (b >= 1 && b <= 8) cap[i][b-1] = line[base];
            end
        end
    endtask

    task automatic pulse_req();
        @(negedge clk);
        dump_req = 1'b1;
        @(posedge clk);
        #1 dump_req = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rd_addr !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: tx=%b busy=%b done=%b addr=%h, expected tx=1 busy=0 done=0 addr=00",
                     tx_out, busy, done, rd_addr);
        end
        reset_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_out !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_after_reset: %0d clks with tx low or busy, expected 0", bad);
        end
    endtask

    task automatic test_single_frame();
        load_ram(1, 1);
        pulse_req();
        capture_frame();
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (cap[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL frame1_byte%0d: got %h expected %h", i, cap[i], exp_b[i]);
            end
        end
        checks++;
        if (exp_b[11] !== 8'h37) begin
            errors++;
            $display("FAIL frame1_model_chk: model %h expected 37", exp_b[11]);
        end
        checks++;
        if (glitch != 0) begin
            errors++;
            $display("FAIL frame1_bit_timing: %0d bad samples, expected 0", glitch);
        end
        checks++;
        if (busy_cnt != 1200 || post_busy !== 1'b0) begin
            errors++;
            $display("FAIL frame1_busy: busy clks %0d after=%b, expected 1200 after=0", busy_cnt, post_busy);
        end
        checks++;
        if (done_cnt != 0 || post_done !== 1'b1) begin
            errors++;
            $display("FAIL frame1_done: done in frame %0d at end=%b, expected 0 and 1", done_cnt, post_done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || rd_addr !== 8'h09) begin
            errors++;
            $display("FAIL frame1_after: done=%b addr=%h, expected done=0 addr=09", done, rd_addr);
        end
    endtask

    task automatic test_wrap();
        load_ram(0, 255);
        repeat (5) @(negedge clk);
        pulse_req();
        capture_frame();
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (cap[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL wrap_byte%0d: got %h expected %h", i, cap[i], exp_b[i]);
            end
        end
        checks++;
        if (cap[11] !== 8'hF6) begin
            errors++;
            $display("FAIL wrap_chk: got %h expected f6", cap[11]);
        end
        checks++;
        if (addr0 !== 8'h00 || glitch != 0) begin
            errors++;
            $display("FAIL wrap_addr_timing: addr at start %h glitches %0d, expected 00 and 0", addr0, glitch);
        end
    endtask

    task automatic test_ignore_busy();
        int bad;
        load_ram(3, 7);
        repeat (5) @(negedge clk);
        pulse_req();
        fork
            capture_frame();
            begin
                repeat (300) @(negedge clk);
                dump_req = 1'b1;
                @(negedge clk);
                dump_req = 1'b0;
                repeat (399) @(negedge clk);
                dump_req = 1'b1;
                @(negedge clk);
                dump_req = 1'b0;
            end
        join
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (cap[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL ignore_byte%0d: got %h expected %h", i, cap[i], exp_b[i]);
            end
        end
        bad = 0;
        repeat (1300) begin
            @(negedge clk);
            if (tx_out !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || glitch != 0) begin
            errors++;
            $display("FAIL ignore_no_second: %0d active clks, %0d glitches, expected 0 and 0", bad, glitch);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        load_ram(1, 1);
        @(negedge clk);
        dump_req = 1'b1;
        @(posedge clk);
        capture_frame();
        checks++;
        if (post_done !== 1'b1 || cap[11] !== 8'h37 || busy_cnt != 1200) begin
            errors++;
            $display("FAIL b2b_first: done=%b chk=%h busy clks %0d, expected 1 37 1200",
                     post_done, cap[11], busy_cnt);
        end
        fork
            capture_frame();
            begin
                repeat (600) @(negedge clk);
                dump_req = 1'b0;
            end
        join
        checks++;
        if (line[0] !== 1'b0 || busy_cnt != 1200 || glitch != 0) begin
            errors++;
            $display("FAIL b2b_second_start: tx at clk after done=%b busy clks %0d glitches %0d, expected 0 1200 0",
                     line[0], busy_cnt, glitch);
        end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (cap[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL b2b_byte%0d: got %h expected %h", i, cap[i], exp_b[i]);
            end
        end
        bad = 0;
        repeat (1300) begin
            @(negedge clk);
            if (tx_out !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL b2b_no_third: %0d active clks, expected 0", bad);
        end
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        load_ram(37, 0);
        repeat (5) @(negedge clk);
        pulse_req();
        repeat (450) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (tx_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: tx=%b busy=%b done=%b, expected 1 0 0", tx_out, busy, done);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_out !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midreset_idle: %0d active clks, expected 0", bad);
        end
        pulse_req();
        capture_frame();
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (cap[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL midreset_byte%0d: got %h expected %h", i, cap[i], exp_b[i]);
            end
        end
        checks++;
        if (glitch != 0 || busy_cnt != 1200 || post_done !== 1'b1) begin
            errors++;
            $display("FAIL midreset_frame: glitches %0d busy clks %0d done=%b, expected 0 1200 1",
                     glitch, busy_cnt, post_done);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        test_reset();
        test_single_frame();
        test_wrap();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
